// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Two half-subtractor stages per bit with a registered borrow.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic [CNT_W-1:0] cnt;
  logic             brw;
  logic             d1;
  logic             b1;
  logic             d;
  logic             b2;
  logic             last;

  always_comb begin
    d1      = sa[0] ^ sb[0];
    b1      = ~sa[0] & sb[0];
    d       = d1 ^ brw;
    b2      = ~d1 & brw;
    res_nxt = {d, res[WIDTH-1:1]};
    last    = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // diff/borrow_out only change on the final shift, so they hold between ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            brw <= 1'b0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          brw <= b1 | b2;
          res <= res_nxt;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            diff       <= res_nxt;
            borrow_out <= b1 | b2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit unsigned subtractor, computing diff = a - b, LSB first, one bit per clock.
- Datapath is two cascaded half-subtractor stages (a-b, then minus borrow-in) plus a registered borrow. It is the sequential wrapper that drives the half-subtractor cell.
- Operands are loaded with a start pulse. The block returns a WIDTH-bit difference, a final borrow flag and a one-cycle done strobe.
- Sits between a register-file/operand source and any consumer of the difference.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-count register width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high while a subtraction is in progress (SHIFT state).
- done  output  1  one-cycle strobe; diff/borrow_out valid.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flop and bit counter cleared.
  - Reset asserted mid-operation aborts immediately, with no done strobe.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0 loads sa<=a, sb<=b, brw<=0, cnt<=0, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT (busy=1), each edge:
  - Stage 1: d1 = sa[0]^sb[0]; b1 = ~sa[0]&sb[0].
  - Stage 2: d = d1^brw; b2 = ~d1&brw.
  - Register updates: brw<=b1|b2; res<={d,res[WIDTH-1:1]}; sa, sb shift right by 1; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift), move to DONE and update diff<=final res and borrow_out<=b1|b2 of the last bit.
- DONE: done=1 for exactly one cycle, busy=0; next edge goes to IDLE.
- Latency: start accepted at E0; busy high for cycles E0..E(WIDTH); done high in the cycle following edge E(WIDTH). Total is WIDTH+1 cycles from accept to done.
- start while busy or in DONE is ignored, with no queuing. Re-issue is accepted in IDLE, so back-to-back throughput is one result per WIDTH+2 cycles.
- a/b may change freely after the accepting edge; only the captured values are used.
- diff and borrow_out are registered. They hold their last value until the next completion (not cleared on start) or until reset.
- Wrap-around: the result is modulo 2^WIDTH; underflow is reported only via borrow_out.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then a=5, b=3, start 1 cycle -> busy for 8 cycles, done pulse in the 9th cycle after accept; diff=0x02, borrow_out=0.
- a=3, b=5 -> diff=0xFE, borrow_out=1; a=0, b=0 -> diff=0x00, borrow_out=0.
- a=0xFF, b=0x01 -> diff=0xFE, borrow_out=0; a=0x00, b=0xFF -> diff=0x01, borrow_out=1. This exercises borrow propagation across all bits.
- Start with a=9, b=4, then pulse start with a=1, b=2 at cycle 3 while busy -> second start ignored; diff=0x05, exactly one done pulse.
- Assert rst at cycle 4 of an operation -> busy=0, done never pulses, diff=0, borrow_out=0 asynchronously; a fresh start after release gives a correct result.
- Random sweep: 200 operand pairs against a reference model of a-b -> diff and borrow_out match every time; done is always exactly one cycle wide.
